// File: rtl/lcd_timing_gen_if.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen_if
//   Pixel-source handshake between the LCD timing generator and the
//   frame-buffer / scaler read path.
//
//   data_req     timing generator -> source : pixel request
//   pixel_xpos   timing generator -> source : x of requested pixel (0 when idle)
//   pixel_ypos   timing generator -> source : y of requested pixel (0 when idle)
//   pixel_data   source -> timing generator : pixel answering an earlier request
//   pixel_valid  source -> timing generator : pixel_data is usable
//
//   master = timing generator, slave = pixel source.
// ---------------------------------------------------------------------------
interface lcd_timing_gen_if #(
    parameter int PIX_W = 16,
    parameter int CNT_W = 11
) ();
    logic             data_req;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic [PIX_W-1:0] pixel_data;
    logic             pixel_valid;

    modport master (
        output data_req,
        output pixel_xpos,
        output pixel_ypos,
        input  pixel_data,
        input  pixel_valid
    );

    modport slave (
        input  data_req,
        input  pixel_xpos,
        input  pixel_ypos,
        output pixel_data,
        output pixel_valid
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
//   RGB LCD timing generator with configurable porches, sync polarities,
//   pixel-request lead, panel power-up sequencer (reset hold, then
//   backlight), frame-start strobe and sticky pixel-underflow flag.
//
//   Ports:
//     lcd_pclk       pixel clock (only clock)
//     rst            synchronous active-high reset
//     src            pixel-source handshake (lcd_timing_gen_if.master)
//     underflow_clr  clears the sticky underflow flag
//     lcd_hs/vs/de   sync / data-enable pins, active level set by *_POL
//     lcd_rgb        pixel to panel, 0 while DE is inactive
//     lcd_clk        forwarded pixel clock
//     lcd_rst        panel reset, active low
//     lcd_bl         backlight enable
//     frame_start    one-cycle pulse on the first cycle of each visible frame
//     underflow      sticky flag: DE was asserted with no valid pixel
//
//   Optional build macro LCD_BL_PWM_EN: adds bl_duty/bl_div inputs and turns
//   lcd_bl into an 8-bit PWM (period (bl_div+1)*256 clocks) while running.
// ---------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter int PIX_W      = 16,
    parameter int CNT_W      = 11,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int H_DISP     = 800,
    parameter int H_FRONT    = 40,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_DISP     = 480,
    parameter int V_FRONT    = 10,
    parameter int REQ_LEAD   = 1,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter bit DE_POL     = 1'b1,
    parameter int RST_CYCLES = 1024
) (
    input  logic             lcd_pclk,
    input  logic             rst,
    lcd_timing_gen_if.master src,
    input  logic             underflow_clr,
`ifdef LCD_BL_PWM_EN
    input  logic [7:0]       bl_duty,
    input  logic [7:0]       bl_div,
`endif
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic [PIX_W-1:0] lcd_rgb,
    output logic             lcd_clk,
    output logic             lcd_rst,
    output logic             lcd_bl,
    output logic             frame_start,
    output logic             underflow
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;
    localparam int RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] DE_H_BEG = CNT_W'(HA);
    localparam logic [CNT_W-1:0] DE_H_END = CNT_W'(HA + H_DISP);
    localparam logic [CNT_W-1:0] RQ_H_BEG = CNT_W'(HA - REQ_LEAD);
    localparam logic [CNT_W-1:0] RQ_H_END = CNT_W'(HA + H_DISP - REQ_LEAD);
    localparam logic [CNT_W-1:0] ACT_V_BEG = CNT_W'(VA);
    localparam logic [CNT_W-1:0] ACT_V_END = CNT_W'(VA + V_DISP);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    seq_state_e       state_q;
    logic [RC_W-1:0]  rst_cnt_q;
    logic             lcd_rst_q;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] xpos_q, xpos_d;
    logic [CNT_W-1:0] ypos_q, ypos_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             bl_q, bl_d;
    logic             fs_q, fs_d;
    logic             uf_q, uf_d;

    logic             at_origin;
    logic             run_next;
    logic             v_act;
    logic             de_on;
    logic             req_on;

`ifdef LCD_BL_PWM_EN
    logic [7:0]       div_q, div_d;
    logic [7:0]       phase_q, phase_d;
`endif

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end

        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        // True when the sequencer will be in RUN after this edge; the entry
        // edge already counts so frame_start and the backlight line up.
        run_next  = (state_q == ST_RUN) || ((state_q == ST_WAIT) && at_origin);

        v_act  = (v_cnt_q >= ACT_V_BEG) && (v_cnt_q < ACT_V_END);
        // Request/DE gating uses the current state: on the RUN entry edge
        // the counters sit at the origin where both are inactive anyway.
        de_on  = (state_q == ST_RUN) && v_act &&
                 (h_cnt_q >= DE_H_BEG) && (h_cnt_q < DE_H_END);
        req_on = (state_q == ST_RUN) && v_act &&
                 (h_cnt_q >= RQ_H_BEG) && (h_cnt_q < RQ_H_END);

        hs_d   = (h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
        vs_d   = (v_cnt_q < VS_END) ? VS_POL : ~VS_POL;
        de_d   = de_on ? DE_POL : ~DE_POL;
        req_d  = req_on;
        xpos_d = req_on ? (h_cnt_q - RQ_H_BEG) : '0;
        ypos_d = req_on ? (v_cnt_q - ACT_V_BEG) : '0;

        // A missing pixel is blanked rather than showing stale bus data.
        rgb_d  = (de_on && src.pixel_valid) ? src.pixel_data : '0;
        fs_d   = run_next && at_origin;

        // Set has priority over clear so a new underflow is never lost.
        uf_d   = uf_q;
        if (de_on && !src.pixel_valid) begin
            uf_d = 1'b1;
        end else if (underflow_clr) begin
            uf_d = 1'b0;
        end

`ifdef LCD_BL_PWM_EN
        div_d   = div_q + 1'b1;
        phase_d = phase_q;
        if (div_q >= bl_div) begin
            div_d   = '0;
            phase_d = phase_q + 1'b1;
        end
        bl_d    = run_next && (phase_q < bl_duty);
`else
        bl_d    = run_next;
`endif
    end

    // Power-up sequencer: hold panel in reset, wait for a frame boundary,
    // then run.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            rst_cnt_q <= '0;
            lcd_rst_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (rst_cnt_q == RC_LAST) begin
                        state_q   <= ST_WAIT;
                        lcd_rst_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (at_origin) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q   <= ST_HOLD;
                    rst_cnt_q <= '0;
                    lcd_rst_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= ~DE_POL;
            req_q   <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            rgb_q   <= '0;
            bl_q    <= 1'b0;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
`ifdef LCD_BL_PWM_EN
            div_q   <= '0;
            phase_q <= '0;
`endif
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            req_q   <= req_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            rgb_q   <= rgb_d;
            bl_q    <= bl_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
`ifdef LCD_BL_PWM_EN
            div_q   <= div_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign src.data_req   = req_q;
    assign src.pixel_xpos = xpos_q;
    assign src.pixel_ypos = ypos_q;
    assign lcd_hs         = hs_q;
    assign lcd_vs         = vs_q;
    assign lcd_de         = de_q;
    assign lcd_rgb        = rgb_q;
    assign lcd_clk        = lcd_pclk;
    assign lcd_rst        = lcd_rst_q;
    assign lcd_bl         = bl_q;
    assign frame_start    = fs_q;
    assign underflow      = uf_q;

endmodule
